// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit holding the MIPS HI/LO registers.
// MULT/MULTU/DIV/DIVU run for WIDTH+1 cycles (WIDTH RUN steps plus one FIX
// cycle) on operand magnitudes, with the sign fixed up in FIX.
// MTHI/MTLO write HI/LO directly on the accepting edge.
//
// Ports:
//   i_clk    rising-edge clock
//   i_reset  synchronous active-high reset
//   i_start  issue request; accepted when o_busy=0 and i_flush=0
//   i_op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//            11x ignored
//   i_a      rs operand (multiplicand / dividend / MT source)
//   i_b      rt operand (multiplier / divisor)
//   i_flush  cancels a running op and blocks acceptance this cycle
//   o_busy   registered; high while a multiply/divide is in flight
//   o_done   registered one-cycle pulse after HI/LO are written by MULT/DIV
//   o_hi     HI register
//   o_lo     LO register
module mips_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;   // negate product (mul) or quotient (div)
  logic               r_neg_hi;   // negate remainder (div)
  logic [WIDTH-1:0]   r_mb;       // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0] r_p;        // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_p_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_accept = i_start & ~i_flush & ~r_busy;
  // op[0]=0 selects the signed variants of MULT/DIV
  assign w_a_neg  = ~i_op[0] & i_a[WIDTH-1];
  assign w_b_neg  = ~i_op[0] & i_b[WIDTH-1];
  assign w_b_zero = (i_b == '0);
  assign w_abs_a  = w_a_neg ? -i_a : i_a;
  assign w_abs_b  = w_b_neg ? -i_b : i_b;

  always_comb begin
    // multiply: add multiplicand into the upper half when the LSB is set, shift right
    w_add   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_mb} : '0);
    // divide: shift the next dividend bit into the remainder and trial-subtract;
    // the remainder always stays below the divisor, so bit WIDTH of the difference is its sign
    w_shift = r_p[2*WIDTH-1:WIDTH-1];
    w_diff  = w_shift - {1'b0, r_mb};
    if (r_is_div) begin
      if (!w_diff[WIDTH]) begin
        w_p_next = {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
      end else begin
        w_p_next = {w_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_p_next = {w_add, r_p[WIDTH-1:1]};
    end
  end

  assign w_prod = r_neg_lo ? -r_p : r_p;
  assign w_quo  = r_neg_lo ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem  = r_neg_hi ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_mb     <= '0;
      r_p      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!i_op[2]) begin
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
              r_cnt    <= CW'(WIDTH - 1);
              r_is_div <= i_op[1];
              r_mb     <= w_abs_b;
              r_p      <= {{WIDTH{1'b0}}, w_abs_a};
              // divide by zero keeps the all-ones quotient unnegated
              r_neg_lo <= (w_a_neg ^ w_b_neg) & ~(i_op[1] & w_b_zero);
              r_neg_hi <= i_op[1] & w_a_neg;
            end else if (i_op[1:0] == 2'b00) begin
              r_hi <= i_a;
            end else if (i_op[1:0] == 2'b01) begin
              r_lo <= i_a;
            end
          end
        end
        S_RUN: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!i_flush) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
